// File: rtl/draw_dog_pkg.sv
// Shared types and constants for the draw_dog sprite stage: behaviour states,
// ROM frame indices, path waypoints and a constant shift-add multiplier.
package draw_dog_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WALK, ST_SNIFF, ST_JUMP_UP, ST_JUMP_DN,
    ST_HIDDEN, ST_POP_UP, ST_HOLD, ST_POP_DN
  } dog_state_t;

  localparam logic [3:0] DOG_FR_WALK0   = 4'd0;
  localparam logic [3:0] DOG_FR_SNIFF   = 4'd4;
  localparam logic [3:0] DOG_FR_JUMP_UP = 4'd5;
  localparam logic [3:0] DOG_FR_JUMP_DN = 4'd6;
  localparam logic [3:0] DOG_FR_LAUGH   = 4'd7;
  localparam logic [3:0] DOG_FR_HOLD    = 4'd8;

  localparam logic [10:0] DOG_X_SNIFF    = 11'd200;
  localparam logic [10:0] DOG_Y_JUMP_TOP = 11'd380;
  localparam logic [10:0] DOG_Y_WALK     = 11'd440;

  // Multiply by a constant using only shifted adds, so no DSP block is inferred.
  function automatic logic [12:0] mul_const(input logic [12:0] a, input int k);
    logic [12:0] acc;
    acc = 13'd0;
    for (int i = 0; i < 13; i++) begin
      if (k[i]) acc = acc + (a << i);
      else      acc = acc;
    end
    return acc;
  endfunction

endpackage

// File: rtl/draw_dog_if.sv
// VGA pixel/timing bundle passed through the draw_dog stage.
interface draw_dog_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_dog_anim_fsm.sv
// Dog behaviour state machine: position, ROM frame, step counter and pending
// request flags, all advanced once per frame tick. DOG_DEBUG_BOX_EN adds o_active.
module dog_anim_fsm
  import draw_dog_pkg::*;
#(
  parameter int DOG_H    = 46,
  parameter int GRASS_Y  = 560,
  parameter int ANIM_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_tick,
  input  logic        i_round_start,
  input  logic        i_duck_caught,
  input  logic        i_duck_escaped,
  output logic [10:0] o_xpos,
  output logic [10:0] o_ypos,
  output logic [3:0]  o_dog_select,
  output logic        o_visible,
  output logic        o_dog_busy
`ifdef DOG_DEBUG_BOX_EN
  , output logic      o_active
`endif
);

  localparam logic [10:0] Y_GRASS    = 11'(GRASS_Y);
  localparam logic [10:0] Y_TOP      = 11'(GRASS_Y - DOG_H);
  localparam logic [7:0]  STEP_SNIFF = 8'(4 * ANIM_DIV - 1);
  localparam logic [7:0]  STEP_HOLD  = 8'(8 * ANIM_DIV - 1);

  dog_state_t  r_state;
  logic [10:0] r_xpos, r_ypos;
  logic [3:0]  r_dog_select;
  logic        r_dog_busy;
  logic [7:0]  r_step;
  logic        r_start_pend, r_caught_pend, r_escaped_pend;

  logic        w_start, w_caught, w_escaped, w_bob;
  logic [10:0] w_x_next, w_y_up1, w_y_up2, w_y_dn1, w_y_dn3;
  logic [3:0]  w_walk_fr;

  // A pulse arriving on the tick itself counts as already pending.
  assign w_start   = r_start_pend   | i_round_start;
  assign w_caught  = r_caught_pend  | i_duck_caught;
  assign w_escaped = r_escaped_pend | i_duck_escaped;

  assign w_x_next  = r_xpos + 11'd1;
  assign w_walk_fr = 4'((w_x_next / 11'(ANIM_DIV)) & 11'd3);
  assign w_y_up1   = (r_ypos >= 11'd1) ? r_ypos - 11'd1 : 11'd0;
  assign w_y_up2   = (r_ypos >= 11'd2) ? r_ypos - 11'd2 : 11'd0;
  assign w_y_dn1   = r_ypos + 11'd1;
  assign w_y_dn3   = r_ypos + 11'd3;
  assign w_bob     = ((r_step / 8'(ANIM_DIV)) & 8'd1) != 8'd0;

  // Behaviour state, position, frame and pending-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_xpos         <= 11'd0;
      r_ypos         <= Y_GRASS;
      r_dog_select   <= DOG_FR_WALK0;
      r_dog_busy     <= 1'b0;
      r_step         <= 8'd0;
      r_start_pend   <= 1'b0;
      r_caught_pend  <= 1'b0;
      r_escaped_pend <= 1'b0;
    end else begin
      r_start_pend   <= w_start & ~r_dog_busy;
      r_caught_pend  <= w_caught & (r_state == ST_HIDDEN);
      r_escaped_pend <= w_escaped & (r_state == ST_HIDDEN);
      if (i_frame_tick) begin
        case (r_state)
          ST_IDLE, ST_HIDDEN: begin
            if ((r_state == ST_HIDDEN) && (w_caught || w_escaped)) begin
              r_state        <= ST_POP_UP;
              r_dog_select   <= w_caught ? DOG_FR_HOLD : DOG_FR_LAUGH;
              r_dog_busy     <= 1'b1;
              r_caught_pend  <= 1'b0;
              r_escaped_pend <= 1'b0;
              r_start_pend   <= 1'b0;
            end else if (w_start) begin
              r_state      <= ST_WALK;
              r_xpos       <= 11'd0;
              r_ypos       <= DOG_Y_WALK;
              r_dog_select <= DOG_FR_WALK0;
              r_dog_busy   <= 1'b1;
              r_step       <= 8'd0;
              r_start_pend <= 1'b0;
            end
          end
          ST_WALK: begin
            r_xpos <= w_x_next;
            if (w_x_next == DOG_X_SNIFF) begin
              r_state      <= ST_SNIFF;
              r_dog_select <= DOG_FR_SNIFF;
              r_step       <= 8'd0;
            end else begin
              r_dog_select <= w_walk_fr;
            end
          end
          ST_SNIFF: begin
            if (r_step == STEP_SNIFF) begin
              r_state      <= ST_JUMP_UP;
              r_dog_select <= DOG_FR_JUMP_UP;
              r_step       <= 8'd0;
            end else begin
              r_step <= r_step + 8'd1;
            end
          end
          ST_JUMP_UP: begin
            r_ypos <= w_y_up2;
            if (w_y_up2 <= DOG_Y_JUMP_TOP) begin
              r_state      <= ST_JUMP_DN;
              r_dog_select <= DOG_FR_JUMP_DN;
            end
          end
          ST_JUMP_DN: begin
            r_ypos <= w_y_dn3;
            if (w_y_dn3 >= Y_GRASS) begin
              r_state    <= ST_HIDDEN;
              r_dog_busy <= 1'b0;
            end
          end
          ST_POP_UP: begin
            r_ypos <= w_y_up1;
            if (w_y_up1 <= Y_TOP) begin
              r_state <= ST_HOLD;
              r_step  <= 8'd0;
            end
          end
          ST_HOLD: begin
            if (r_step == STEP_HOLD) begin
              r_state <= ST_POP_DN;
              r_step  <= 8'd0;
            end else begin
              r_step <= r_step + 8'd1;
            end
          end
          ST_POP_DN: begin
            r_ypos <= w_y_dn1;
            if (w_y_dn1 >= Y_GRASS) begin
              r_state    <= ST_HIDDEN;
              r_dog_busy <= 1'b0;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_dog_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_xpos       = r_xpos;
  assign o_ypos       = r_ypos;
  assign o_dog_select = r_dog_select;
  assign o_dog_busy   = r_dog_busy;
  // The laugh frame blinks on alternate animation steps while held up.
  assign o_visible    = r_dog_busy &&
                        !((r_state == ST_HOLD) && (r_dog_select == DOG_FR_LAUGH) && w_bob);
`ifdef DOG_DEBUG_BOX_EN
  assign o_active     = (r_state != ST_IDLE);
`endif

endmodule

// File: rtl/draw_dog.sv
// Dog sprite draw stage: ROM address generation and colour-keyed overlay with a
// 2-cycle aligned VGA pipeline. DOG_DEBUG_BOX_EN draws a red bounding-box outline.
module draw_dog
  import draw_dog_pkg::*;
#(
  parameter int          DOG_W     = 56,
  parameter int          DOG_H     = 46,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  parameter int          GRASS_Y   = 560,
  parameter int          ANIM_DIV  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  draw_dog_if.slave         vga_in,
  draw_dog_if.master        vga_out,
  input  logic              round_start,
  input  logic              duck_caught,
  input  logic              duck_escaped,
  input  logic [11:0]       rom_rgb,
  output logic [12:0]       rom_address,
  output logic [3:0]        dog_select,
  output logic              dog_busy
);

  logic        r_vblnk_d;
  logic        w_frame_tick, w_visible;
  logic [10:0] w_xpos, w_ypos, w_x_rel, w_y_rel;
  logic [11:0] w_x_end, w_y_end;
  logic        w_in_x, w_in_y, w_in_box;
  logic [12:0] w_addr;
  logic [11:0] w_rgb_sel;

  logic [12:0] r_addr;
  logic        r_in_box1, r_visible1;
  logic [10:0] r_hcount1, r_vcount1, r_hcount2, r_vcount2;
  logic        r_hsync1, r_vsync1, r_hblnk1, r_vblnk1;
  logic        r_hsync2, r_vsync2, r_hblnk2, r_vblnk2;
  logic [11:0] r_rgb1, r_rgb2;

  assign w_frame_tick = vga_in.vblnk & ~r_vblnk_d;

  dog_anim_fsm #(.DOG_H(DOG_H), .GRASS_Y(GRASS_Y), .ANIM_DIV(ANIM_DIV)) u_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_frame_tick   (w_frame_tick),
    .i_round_start  (round_start),
    .i_duck_caught  (duck_caught),
    .i_duck_escaped (duck_escaped),
    .o_xpos         (w_xpos),
    .o_ypos         (w_ypos),
    .o_dog_select   (dog_select),
    .o_visible      (w_visible),
    .o_dog_busy     (dog_busy)
`ifdef DOG_DEBUG_BOX_EN
    , .o_active     (w_active)
`endif
  );

  // 12-bit end coordinates so xpos+DOG_W cannot wrap.
  assign w_x_end  = {1'b0, w_xpos} + 12'(DOG_W);
  assign w_y_end  = {1'b0, w_ypos} + 12'(DOG_H);
  assign w_in_x   = (vga_in.hcount >= w_xpos) && ({1'b0, vga_in.hcount} < w_x_end);
  assign w_in_y   = (vga_in.vcount >= w_ypos) && ({1'b0, vga_in.vcount} < w_y_end);
  assign w_in_box = w_in_x && w_in_y && (vga_in.vcount < 11'(GRASS_Y));
  assign w_x_rel  = vga_in.hcount - w_xpos;
  assign w_y_rel  = vga_in.vcount - w_ypos;
  assign w_addr   = mul_const({2'b00, w_y_rel}, DOG_W) + {2'b00, w_x_rel};

`ifdef DOG_DEBUG_BOX_EN
  logic w_active, w_edge, r_edge1, r_active1;
  assign w_edge = w_in_x && w_in_y &&
                  ((w_x_rel == 11'd0) || (w_x_rel == 11'(DOG_W - 1)) ||
                   (w_y_rel == 11'd0) || (w_y_rel == 11'(DOG_H - 1)));

  // Outline qualifiers aligned with the stage-1 address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge1   <= 1'b0;
      r_active1 <= 1'b0;
    end else begin
      r_edge1   <= w_edge;
      r_active1 <= w_active;
    end
  end
`endif

  // Stage 1: frame-edge detect, ROM address, box flag and delayed timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblnk_d  <= 1'b0;
      r_addr     <= 13'd0;
      r_in_box1  <= 1'b0;
      r_visible1 <= 1'b0;
      r_hcount1  <= 11'd0;
      r_vcount1  <= 11'd0;
      r_hsync1   <= 1'b0;
      r_vsync1   <= 1'b0;
      r_hblnk1   <= 1'b0;
      r_vblnk1   <= 1'b0;
      r_rgb1     <= 12'd0;
    end else begin
      r_vblnk_d  <= vga_in.vblnk;
      r_addr     <= w_in_box ? w_addr : 13'd0;
      r_in_box1  <= w_in_box;
      r_visible1 <= w_visible;
      r_hcount1  <= vga_in.hcount;
      r_vcount1  <= vga_in.vcount;
      r_hsync1   <= vga_in.hsync;
      r_vsync1   <= vga_in.vsync;
      r_hblnk1   <= vga_in.hblnk;
      r_vblnk1   <= vga_in.vblnk;
      r_rgb1     <= vga_in.rgb;
    end
  end

  // Overlay select against the ROM word returned for the stage-1 address.
  always_comb begin
    w_rgb_sel = r_rgb1;
`ifdef DOG_DEBUG_BOX_EN
    if (r_edge1 && r_active1 && !(r_hblnk1 || r_vblnk1)) begin
      w_rgb_sel = 12'hF00;
    end else
`endif
    if (r_in_box1 && r_visible1 && (rom_rgb != KEY_COLOR) && !(r_hblnk1 || r_vblnk1)) begin
      w_rgb_sel = rom_rgb;
    end else begin
      w_rgb_sel = r_rgb1;
    end
  end

  // Stage 2: registered pixel and timing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount2 <= 11'd0;
      r_vcount2 <= 11'd0;
      r_hsync2  <= 1'b0;
      r_vsync2  <= 1'b0;
      r_hblnk2  <= 1'b0;
      r_vblnk2  <= 1'b0;
      r_rgb2    <= 12'd0;
    end else begin
      r_hcount2 <= r_hcount1;
      r_vcount2 <= r_vcount1;
      r_hsync2  <= r_hsync1;
      r_vsync2  <= r_vsync1;
      r_hblnk2  <= r_hblnk1;
      r_vblnk2  <= r_vblnk1;
      r_rgb2    <= w_rgb_sel;
    end
  end

  assign rom_address    = r_addr;
  assign vga_out.hcount = r_hcount2;
  assign vga_out.vcount = r_vcount2;
  assign vga_out.hsync  = r_hsync2;
  assign vga_out.vsync  = r_vsync2;
  assign vga_out.hblnk  = r_hblnk2;
  assign vga_out.vblnk  = r_vblnk2;
  assign vga_out.rgb    = r_rgb2;

endmodule

// File: tb/tb_draw_dog.sv
// Table-driven bench for draw_dog: advances frames, probes one pixel per row and
// checks frame select, busy, ROM address, overlay colour and timing alignment.
module tb_draw_dog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        round_start, duck_caught, duck_escaped;
  logic [11:0] rom_rgb;
  logic [12:0] rom_address;
  logic [3:0]  dog_select;
  logic        dog_busy;

  draw_dog_if vin ();
  draw_dog_if vout ();

  draw_dog dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_in       (vin),
    .vga_out      (vout),
    .round_start  (round_start),
    .duck_caught  (duck_caught),
    .duck_escaped (duck_escaped),
    .rom_rgb      (rom_rgb),
    .rom_address  (rom_address),
    .dog_select   (dog_select),
    .dog_busy     (dog_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          act;   // 0 none, 1 start on first tick, 2 caught+escaped, 3 escaped, 4 start pulse
    int          adv;   // frame ticks before the probe
    logic [10:0] h, v;
    logic        blk;
    logic [11:0] rom;
    logic [3:0]  sel;
    logic        busy;
    logic [12:0] addr;
    logic        ovl;   // 1: expect the ROM word on rgb_out
  } vec_t;

  localparam int NV = 34;
  vec_t tv [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(int act, int adv, int h, int v, int blk, int rom,
                              int sel, int busy, int addr, int ovl);
    vec_t r;
    r.act = act; r.adv = adv; r.h = 11'(h); r.v = 11'(v); r.blk = 1'(blk);
    r.rom = 12'(rom); r.sel = 4'(sel); r.busy = 1'(busy); r.addr = 13'(addr); r.ovl = 1'(ovl);
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, got, want);
    end
  endtask

  task automatic frame(input bit st);
    @(negedge clk); vin.vblnk = 1'b1; round_start = st;
    @(negedge clk); vin.vblnk = 1'b0; round_start = 1'b0;
  endtask

  task automatic pulse(input bit s, input bit c, input bit e);
    @(negedge clk); round_start = s; duck_caught = c; duck_escaped = e;
    @(negedge clk); round_start = 1'b0; duck_caught = 1'b0; duck_escaped = 1'b0;
  endtask

  task automatic probe(input logic [10:0] h, input logic [10:0] v, input logic blk,
                       input logic [11:0] bg, input logic [11:0] rom,
                       output logic [12:0] addr, output logic [11:0] rgb,
                       output logic hs, output logic [10:0] hc);
    @(negedge clk);
    vin.hcount = h; vin.vcount = v; vin.hblnk = blk; vin.hsync = 1'b1; vin.rgb = bg;
    @(negedge clk);
    addr = rom_address; rom_rgb = rom;
    vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hblnk = 1'b0; vin.hsync = 1'b0; vin.rgb = 12'h555;
    @(negedge clk);
    rgb = vout.rgb; hs = vout.hsync; hc = vout.hcount; rom_rgb = 12'h000;
  endtask

  initial begin
    logic [12:0] a;
    logic [11:0] c, bg, exp_rgb;
    logic        hs;
    logic [10:0] hc;

    //            act adv   h    v  blk  rom    sel busy addr ovl
    tv[0]  = mk(2,   2,    3,   2, 0, 'hABC, 0, 0,    0, 0);
    tv[1]  = mk(1,   1,    3, 442, 0, 'hABC, 0, 1,  115, 1);
    tv[2]  = mk(2,   8,   63, 485, 0, 'hABC, 1, 1, 2575, 1);
    tv[3]  = mk(0,   8,   72, 441, 0, 'hABC, 2, 1,    0, 0);
    tv[4]  = mk(0,   8,   34, 485, 0, 'hABC, 3, 1, 2530, 1);
    tv[5]  = mk(0,   8,   33, 441, 0, 'hABC, 0, 1,   57, 1);
    tv[6]  = mk(0,   0,   31, 441, 0, 'hABC, 0, 1,    0, 0);
    tv[7]  = mk(0, 167,  202, 442, 0, 'hABC, 0, 1,  115, 1);
    tv[8]  = mk(0,   1,  203, 442, 0, 'h7E1, 4, 1,  115, 1);
    tv[9]  = mk(0,   0,  203, 442, 0, 'hF0F, 4, 1,  115, 0);
    tv[10] = mk(0,   0,  203, 442, 1, 'hABC, 4, 1,  115, 0);
    tv[11] = mk(0,  31,  203, 442, 0, 'hABC, 4, 1,  115, 1);
    tv[12] = mk(0,   1,  203, 442, 0, 'hABC, 5, 1,  115, 1);
    tv[13] = mk(0,   1,  201, 439, 0, 'hABC, 5, 1,   57, 1);
    tv[14] = mk(0,  29,  200, 381, 0, 'hABC, 6, 1,   56, 1);
    tv[15] = mk(0,  59,  201, 559, 0, 'hABC, 6, 1,  113, 1);
    tv[16] = mk(0,   0,  201, 560, 0, 'hABC, 6, 1,    0, 0);
    tv[17] = mk(0,   1,  201, 559, 0, 'hABC, 6, 0,    0, 0);
    tv[18] = mk(0,   1,  201, 559, 0, 'hABC, 6, 0,    0, 0);
    tv[19] = mk(2,   1,  201, 559, 0, 'hABC, 8, 1,    0, 0);
    tv[20] = mk(0,  45,  202, 516, 0, 'hABC, 8, 1,   58, 1);
    tv[21] = mk(0,   1,  255, 559, 0, 'hABC, 8, 1, 2575, 1);
    tv[22] = mk(0,  63,  255, 559, 0, 'hABC, 8, 1, 2575, 1);
    tv[23] = mk(0,   1,  201, 515, 0, 'hABC, 8, 1,   57, 1);
    tv[24] = mk(0,  45,  201, 559, 0, 'hABC, 8, 1,    1, 1);
    tv[25] = mk(0,   1,  201, 559, 0, 'hABC, 8, 0,    0, 0);
    tv[26] = mk(3,   1,  201, 559, 0, 'hABC, 7, 1,    0, 0);
    tv[27] = mk(0,  46,  202, 516, 0, 'hABC, 7, 1,  114, 1);
    tv[28] = mk(0,   8,  202, 516, 0, 'hABC, 7, 1,  114, 0);
    tv[29] = mk(4,   8,  202, 516, 0, 'hABC, 7, 1,  114, 1);
    tv[30] = mk(0,  48,  201, 515, 0, 'hABC, 7, 1,   57, 1);
    tv[31] = mk(0,  47,  201, 559, 0, 'hABC, 7, 0,    0, 0);
    tv[32] = mk(1,   1,    3, 442, 0, 'hABC, 0, 1,  115, 1);
    tv[33] = mk(0, 237,  203, 432, 0, 'hABC, 5, 1,  115, 1);

    rst_n = 1'b0; round_start = 1'b0; duck_caught = 1'b0; duck_escaped = 1'b0; rom_rgb = 12'h000;
    vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_rgb_addr", -1, {vout.rgb, rom_address}, 32'd0);
    chk("rst_sel_busy_sync", -1, {dog_select, dog_busy, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 32'd0);
    chk("rst_counts", -1, {vout.hcount, vout.vcount}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_outs", -1, {vout.rgb, rom_address, dog_busy}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      case (tv[i].act)
        2:       pulse(1'b0, 1'b1, 1'b1);
        3:       pulse(1'b0, 1'b0, 1'b1);
        4:       pulse(1'b1, 1'b0, 1'b0);
        default: ;
      endcase
      for (int f = 0; f < tv[i].adv; f++) frame(tv[i].act == 1 && f == 0);
      bg = 12'h100 + 12'(i);
      probe(tv[i].h, tv[i].v, tv[i].blk, bg, tv[i].rom, a, c, hs, hc);
      exp_rgb = tv[i].ovl ? tv[i].rom : bg;
      chk("dog_select", i, dog_select, tv[i].sel);
      chk("dog_busy", i, dog_busy, tv[i].busy);
      chk("rom_address", i, a, tv[i].addr);
      chk("rgb_out", i, c, exp_rgb);
      chk("hsync_out", i, hs, 1'b1);
      chk("hcount_out", i, hc, tv[i].h);
    end

    // Asynchronous reset in the middle of JUMP_UP.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rgb_addr", 99, {vout.rgb, rom_address}, 32'd0);
    chk("async_rst_sel_busy", 99, {dog_select, dog_busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) frame(1'b0);
    chk("idle_after_rst_busy", 100, dog_busy, 1'b0);
    chk("idle_after_rst_sel", 100, dog_select, 4'd0);
    probe(11'd203, 11'd432, 1'b0, 12'h2A2, 12'hABC, a, c, hs, hc);
    chk("idle_after_rst_addr", 100, a, 13'd0);
    chk("idle_after_rst_rgb", 100, c, 12'h2A2);
    frame(1'b1);
    probe(11'd3, 11'd442, 1'b0, 12'h2A3, 12'hABC, a, c, hs, hc);
    chk("restart_busy", 101, dog_busy, 1'b1);
    chk("restart_addr", 101, a, 13'd115);
    chk("restart_rgb", 101, c, 12'hABC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
